// File: rtl/uart_tx_scheduler_if.sv
// UART TX scheduler bus: CPU push/status side plus UART transmitter handshake.
// master = CPU/UART environment, slave = the scheduler.
interface uart_tx_scheduler_if #(
    parameter int LVL_W = 5
);
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             flush;
    logic             ovf_clr;
    logic             tx_busy;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             fifo_empty;
    logic             fifo_full;
    logic [LVL_W-1:0] fifo_level;
    logic             overflow;
    logic             timeout;

    modport master (
        output wr_en, wr_data, flush, ovf_clr, tx_busy,
        input  tx_start, tx_data, fifo_empty, fifo_full,
        input  fifo_level, overflow, timeout
    );

    modport slave (
        input  wr_en, wr_data, flush, ovf_clr, tx_busy,
        output tx_start, tx_data, fifo_empty, fifo_full,
        output fifo_level, overflow, timeout
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// UART TX scheduler: byte FIFO between CPU stores and the UART transmitter,
// releasing one byte at a time and pacing on the transmitter busy flag.
module uart_tx_scheduler #(
    parameter int DEPTH     = 16,
    parameter int LVL_W     = 5,
    parameter int BUSY_WAIT = 8
) (
    input logic               clk,
    input logic               rst_n,
    uart_tx_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;
    logic             start_q, start_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       mem_q [DEPTH];

    logic pop;
    logic push;
    logic drop;

    // FIFO control: pop only from IDLE, a full FIFO still accepts a push
    // when a pop frees a slot in the same cycle, flush wins over everything.
    always_comb begin
        pop  = (state_q == IDLE) && !empty_q && !bus.tx_busy && !bus.flush;
        push = bus.wr_en && !bus.flush && (!full_q || pop);
        drop = bus.wr_en && !bus.flush && full_q && !pop;
        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_W'(DEPTH));
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Transmit sequencer: start a byte, wait for busy to rise, then to fall.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        start_d = 1'b0;
        data_d  = data_q;
        tmo_d   = bus.ovf_clr ? 1'b0 : tmo_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    data_d  = mem_q[rd_ptr_q];
                    start_d = 1'b1;
                    wcnt_d  = '0;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else if (wcnt_q == 8'(BUSY_WAIT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointers, status and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            start_q  <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
            start_q  <= start_d;
            data_q   <= data_d;
        end
    end

    // FIFO storage; cleared on reset so queued bytes are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.tx_start   = start_q;
    assign bus.tx_data    = data_q;
    assign bus.fifo_empty = empty_q;
    assign bus.fifo_full  = full_q;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = ovf_q;
    assign bus.timeout    = tmo_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: directed pushes queue expected
// bytes, a negedge monitor pops and compares on every tx_start.
module tb_uart_tx_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_scheduler_if #(.LVL_W(5)) bus ();

    uart_tx_scheduler #(
        .DEPTH    (16),
        .LVL_W    (5),
        .BUSY_WAIT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int peak = 0;
    logic [7:0] sb [$];

    logic model_en = 1'b0;
    logic force_busy = 1'b0;
    int busy_cnt = 0;
    logic prev_start = 1'b0;

    assign bus.tx_busy = force_busy | (busy_cnt != 0);

    // UART model: busy for 10 cycles after each start it sees.
    always @(posedge clk) begin
        if (model_en && bus.tx_start) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: each start must match the oldest expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (bus.tx_start) begin
            starts++;
            chk("start_gap", 32'(prev_start), 32'd0);
            chk("busy_at_start", 32'(bus.tx_busy), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_start: got %0h expected none",
                         bus.tx_data);
            end else begin
                e = sb.pop_front();
                chk("tx_data", 32'(bus.tx_data), 32'(e));
            end
        end
        if (32'(bus.fifo_level) > peak) peak = 32'(bus.fifo_level);
        prev_start = bus.tx_start;
    end

    task automatic push(input logic [7:0] b, input bit exp_ok);
        bus.wr_en = 1'b1;
        bus.wr_data = b;
        if (exp_ok) sb.push_back(b);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        repeat (3) @(negedge clk);
        while (bus.tx_busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("idle", 32'(bus.tx_busy), 32'd0);
        cyc(2);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start"}, 32'(bus.tx_start), 32'd0);
        chk({tag, "_data"}, 32'(bus.tx_data), 32'h00);
        chk({tag, "_empty"}, 32'(bus.fifo_empty), 32'd1);
        chk({tag, "_full"}, 32'(bus.fifo_full), 32'd0);
        chk({tag, "_level"}, 32'(bus.fifo_level), 32'd0);
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
        chk({tag, "_tmo"}, 32'(bus.timeout), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int s0;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        bus.flush = 1'b0;
        bus.ovf_clr = 1'b0;
        cyc(2);
        chk_reset("rst");
        rst_n = 1'b1;
        cyc(1);

        // Single byte, busy never rises: latency and timeout.
        push(8'h41, 1'b1);
        @(negedge clk);
        chk("lat_n1", 32'(bus.tx_start), 32'd0);
        @(negedge clk);
        chk("lat_n2", 32'(bus.tx_start), 32'd1);
        n = 0;
        while (!bus.timeout && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_lat", 32'(n), 32'd8);
        chk("timeout", 32'(bus.timeout), 32'd1);
        chk("t1_level", 32'(bus.fifo_level), 32'd0);
        chk("t1_empty", 32'(bus.fifo_empty), 32'd1);
        cyc(1);
        bus.ovf_clr = 1'b1;
        cyc(1);
        bus.ovf_clr = 1'b0;
        chk("tmo_clr", 32'(bus.timeout), 32'd0);

        // Three bytes back to back through the UART model.
        model_en = 1'b1;
        peak = 0;
        push(8'h48, 1'b1);
        push(8'h49, 1'b1);
        push(8'h21, 1'b1);
        wait_drain(200);
        chk("peak", 32'(peak >= 2 && peak <= 3), 32'd1);
        wait_idle(50);

        // Fill while busy, drop the 17th byte.
        force_busy = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(i), i < 16);
        chk("t3_full", 32'(bus.fifo_full), 32'd1);
        chk("t3_level", 32'(bus.fifo_level), 32'd16);
        chk("t3_ovf", 32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        push(8'h11, 1'b0);
        bus.ovf_clr = 1'b0;
        chk("ovf_set_prio", 32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        cyc(1);
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 32'd0);
        force_busy = 1'b0;
        wait_drain(1000);
        wait_idle(50);
        chk("t3_empty", 32'(bus.fifo_empty), 32'd1);
        chk("t3_level0", 32'(bus.fifo_level), 32'd0);

        // Full FIFO, pop and push in the same cycle.
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b1);
        chk("t4_full", 32'(bus.fifo_full), 32'd1);
        force_busy = 1'b0;
        push(8'h30, 1'b1);
        chk("t4_level", 32'(bus.fifo_level), 32'd16);
        chk("t4_ovf", 32'(bus.overflow), 32'd0);
        chk("t4_full2", 32'(bus.fifo_full), 32'd1);
        wait_drain(1000);
        wait_idle(50);

        // Flush with one byte in flight.
        s0 = starts;
        push(8'hA0, 1'b1);
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b0);
        push(8'hA3, 1'b0);
        bus.flush = 1'b1;
        cyc(1);
        bus.flush = 1'b0;
        chk("flush_level", 32'(bus.fifo_level), 32'd0);
        chk("flush_empty", 32'(bus.fifo_empty), 32'd1);
        cyc(40);
        chk("flush_starts", 32'(starts - s0), 32'd1);
        chk("flush_sb", 32'(sb.size()), 32'd0);
        wait_idle(50);

        // Async reset while waiting for busy to fall.
        for (int i = 0; i < 6; i++) push(8'hB0 + 8'(i), 1'b1);
        cyc(2);
        chk("t6_level", 32'(bus.fifo_level), 32'd5);
        chk("t6_data", 32'(bus.tx_data), 32'hB0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        sb.delete();
        cyc(1);
        rst_n = 1'b1;
        s0 = starts;
        cyc(30);
        chk("post_rst_starts", 32'(starts - s0), 32'd0);
        push(8'hC5, 1'b1);
        wait_drain(100);
        wait_idle(50);

        chk("final_sb", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
